scratch_mem_arbiter: RTL

SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

---
 rtl/scratch_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/scratch_mem_arbiter.sv
// Three-requester ownership arbiter for a shared scratch memory with RD_LAT-cycle read latency.
// The owner's traffic is registered onto the memory port, and read-data tags are delayed to match the memory latency.
module scratch_mem_arbiter #(
  parameter int RD_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_release,
  input  logic [2:0]  i_rd_en,
  input  logic [2:0]  i_wt_en,
  input  logic [47:0] i_rd_addr1,
  input  logic [47:0] i_rd_addr2,
  input  logic [47:0] i_wt_addr,
  output logic [2:0]  o_gnt,
  output logic [15:0] o_mem_rd_addr1,
  output logic [15:0] o_mem_rd_addr2,
  output logic [15:0] o_mem_wt_addr,
  output logic        o_mem_rd_en,
  output logic        o_mem_wt_en,
  output logic [2:0]  o_rd_data_vld,
  output logic        o_busy,
  output logic        o_conflict_err
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_gnt, w_gnt_next;
  logic [2:0]  r_drain_cnt, w_cnt_next;
  logic [1:0]  r_last;
  logic [1:0]  w_c0, w_c1, w_c2, w_win_idx;
  logic        w_win_vld;
  logic [2:0]  w_owner_mask, w_acc_rd, w_acc_wt;
  logic        w_rel, w_bad;
  logic [15:0] r_rd_addr1_p1, r_rd_addr2_p1, r_wt_addr_p1;
  logic [2:0]  r_rd_tag_p1;
  logic        r_wt_en_p1;
  logic        r_conflict;
  logic [2:0]  r_tag_sr [RD_LAT];

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [15:0] pick16(input logic [47:0] v, input logic [1:0] idx);
    case (idx)
      2'd1:    return v[31:16];
      2'd2:    return v[47:32];
      default: return v[15:0];
    endcase
  endfunction

  // r_last doubles as the owner index while in OWN
  assign w_c0 = rr_next(r_last);
  assign w_c1 = rr_next(w_c0);
  assign w_c2 = rr_next(w_c1);

  always_comb begin
    w_win_vld = 1'b1;
    w_win_idx = w_c0;
    if (i_req[w_c0])      w_win_idx = w_c0;
    else if (i_req[w_c1]) w_win_idx = w_c1;
    else if (i_req[w_c2]) w_win_idx = w_c2;
    else                  w_win_vld = 1'b0;
  end

  assign w_owner_mask = (r_state == S_OWN) ? r_gnt : 3'b000;
  assign w_acc_rd     = i_rd_en & w_owner_mask;
  assign w_acc_wt     = i_wt_en & w_owner_mask;
  assign w_rel        = |(i_release & w_owner_mask);
  assign w_bad        = |((i_rd_en | i_wt_en | i_release) & ~w_owner_mask);

  always_comb begin
    w_next     = r_state;
    w_gnt_next = r_gnt;
    w_cnt_next = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_next     = S_OWN;
          w_gnt_next = 3'b001 << w_win_idx;
        end
      end
      S_OWN: begin
        if (w_rel) begin
          w_next     = S_DRAIN;
          w_gnt_next = 3'b000;
          w_cnt_next = 3'd0;
        end
      end
      S_DRAIN: begin
        if (w_cnt_next == 3'(RD_LAT)) w_next = S_IDLE;
        else                          w_cnt_next = r_drain_cnt + 3'd1;
      end
      default: begin
        w_next     = S_IDLE;
        w_gnt_next = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= 3'b000;
      r_drain_cnt <= 3'd0;
      r_last      <= 2'd2;
      r_conflict  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_gnt       <= w_gnt_next;
      r_drain_cnt <= w_cnt_next;
      r_conflict  <= r_conflict | w_bad;
      if (r_state == S_IDLE && w_win_vld) r_last <= w_win_idx;
    end
  end

  // Stage p1: owner request registered onto the memory port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_addr1_p1 <= 16'd0;
      r_rd_addr2_p1 <= 16'd0;
      r_wt_addr_p1  <= 16'd0;
      r_rd_tag_p1   <= 3'b000;
      r_wt_en_p1    <= 1'b0;
    end else begin
      r_rd_tag_p1 <= w_acc_rd;
      r_wt_en_p1  <= |w_acc_wt;
      if (r_state == S_OWN) begin
        r_rd_addr1_p1 <= pick16(i_rd_addr1, r_last);
        r_rd_addr2_p1 <= pick16(i_rd_addr2, r_last);
        r_wt_addr_p1  <= pick16(i_wt_addr, r_last);
      end
    end
  end

  // Tag delay line: the last slot lines up with memory read data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) r_tag_sr[i] <= 3'b000;
    end else begin
      r_tag_sr[0] <= r_rd_tag_p1;
      for (int i = 1; i < RD_LAT; i++) r_tag_sr[i] <= r_tag_sr[i-1];
    end
  end

  assign o_gnt          = r_gnt;
  assign o_busy         = (r_state != S_IDLE);
  assign o_conflict_err = r_conflict;
  assign o_mem_rd_addr1 = r_rd_addr1_p1;
  assign o_mem_rd_addr2 = r_rd_addr2_p1;
  assign o_mem_wt_addr  = r_wt_addr_p1;
  assign o_mem_rd_en    = |r_rd_tag_p1;
  assign o_mem_wt_en    = r_wt_en_p1;
  assign o_rd_data_vld  = r_tag_sr[RD_LAT-1];

endmodule
